button_debouncer: RTL and testbench

BUTTON_DEBOUNCER -- requirements
Module: button_debouncer

---
 rtl/button_debouncer.sv | 155 +++++++++++++++
 tb/tb_button_debouncer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/button_debouncer.sv
// Two-channel switch debouncer: 2-flop synchronizer plus a per-channel counting FSM.
// Define BUTTON_DEBOUNCER_EDGE_EN to add the registered btn_rise/btn_fall strobes.

module button_debouncer_ch #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_db
`ifdef BUTTON_DEBOUNCER_EDGE_EN
  ,
  output logic btn_rise,
  output logic btn_fall
`endif
);
  typedef enum logic [1:0] {STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW} state_t;

  localparam logic [CNT_WIDTH-1:0] DB_N = CNT_WIDTH'(DEBOUNCE_CYCLES);
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
  logic                 sync1_q, sync2_q;
  logic                 db_q, db_d;
  logic                 s;

  assign s       = sync2_q;
  assign cnt_inc = cnt_q + ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= STABLE_LOW;
      cnt_q   <= '0;
      db_q    <= 1'b0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
    end
  end

  // cnt reaches DB_N only as the accepting compare, so it never wraps
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      STABLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_inc == DB_N) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = ONE;
        end else begin
          cnt_d = '0;
        end
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_inc == DB_N) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    db_d = (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);
  end

  assign btn_db = db_q;

`ifdef BUTTON_DEBOUNCER_EDGE_EN
  logic rise_q, fall_q;

  // strobes register alongside btn_db, so each is high for the cycle after its edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= db_d & ~db_q;
      fall_q <= ~db_d & db_q;
    end
  end

  assign btn_rise = rise_q;
  assign btn_fall = fall_q;
`else
  // no strobe logic in this build
`endif
endmodule

module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_WIDTH       = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] btn_in,
  output logic [1:0] btn_db
`ifdef BUTTON_DEBOUNCER_EDGE_EN
  ,
  output logic [1:0] btn_rise,
  output logic [1:0] btn_fall
`endif
);
  for (genvar i = 0; i < 2; i++) begin : g_ch
    button_debouncer_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .btn_in  (btn_in[i]),
      .btn_db  (btn_db[i])
`ifdef BUTTON_DEBOUNCER_EDGE_EN
      ,
      .btn_rise(btn_rise[i]),
      .btn_fall(btn_fall[i])
`endif
    );
  end
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer (DEBOUNCE_CYCLES=4) with a queue scoreboard.
module tb_button_debouncer;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] btn_in;
  logic [1:0] btn_db;
`ifdef BUTTON_DEBOUNCER_EDGE_EN
  logic [1:0] btn_rise, btn_fall;
`endif

  typedef struct packed {
    logic [1:0] db;
    logic [1:0] rise;
    logic [1:0] fall;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  logic [1:0] prev_db;

  button_debouncer #(.DEBOUNCE_CYCLES(4), .CNT_WIDTH(16)) dut (
    .clk     (clk),
    .rst     (rst),
    .btn_in  (btn_in),
    .btn_db  (btn_db)
`ifdef BUTTON_DEBOUNCER_EDGE_EN
    ,
    .btn_rise(btn_rise),
    .btn_fall(btn_fall)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive one cycle at negedge, score the registered outputs just after the next posedge
  task automatic cyc(input string tag, input logic r, input logic [1:0] in, input logic [1:0] e);
    exp_t x;
    @(negedge clk);
    rst    = r;
    btn_in = in;
    x.db   = e;
    x.rise = e & ~prev_db;
    x.fall = ~e & prev_db;
    prev_db = e;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk({tag, "_db"}, {14'd0, btn_db}, {14'd0, x.db});
`ifdef BUTTON_DEBOUNCER_EDGE_EN
    chk({tag, "_rise"}, {14'd0, btn_rise}, {14'd0, x.rise});
    chk({tag, "_fall"}, {14'd0, btn_fall}, {14'd0, x.fall});
`endif
  endtask

  task automatic rep(input string tag, input int n, input logic r, input logic [1:0] in,
                     input logic [1:0] e);
    for (int i = 0; i < n; i++) cyc(tag, r, in, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst     = 1'b1;
    btn_in  = 2'b00;
    prev_db = 2'b00;
    #12;
    chk("reset_db",   {14'd0, btn_db}, 16'd0);
    chk("reset_cnt0", dut.g_ch[0].u_ch.cnt_q, 16'd0);
    chk("reset_cnt1", dut.g_ch[1].u_ch.cnt_q, 16'd0);
    rep("rst_hold", 2, 1'b1, 2'b11, 2'b00);

    // both channels held high straight out of reset
    rep("r25_wait", 5, 1'b0, 2'b11, 2'b00);
    cyc("r25_rise",    1'b0, 2'b11, 2'b11);
    rep("r25_hold", 3, 1'b0, 2'b11, 2'b11);
    rep("rel_wait", 5, 1'b0, 2'b00, 2'b11);
    cyc("rel_fall",    1'b0, 2'b00, 2'b00);
    rep("rel_hold", 3, 1'b0, 2'b00, 2'b00);

    // short pulse on ch0 is rejected
    rep("r26_pulse", 3, 1'b0, 2'b01, 2'b00);
    rep("r26_low",   6, 1'b0, 2'b00, 2'b00);
    chk("r26_cnt0", dut.g_ch[0].u_ch.cnt_q, 16'd0);

    // ch1 settles high, chatters, then falls 6 edges after the final 1->0 sample
    rep("r27_wait", 5, 1'b0, 2'b10, 2'b00);
    cyc("r27_rise",    1'b0, 2'b10, 2'b10);
    rep("r27_hold", 3, 1'b0, 2'b10, 2'b10);
    cyc("r27_ch1",     1'b0, 2'b10, 2'b10);
    cyc("r27_ch0",     1'b0, 2'b00, 2'b10);
    cyc("r27_ch1b",    1'b0, 2'b10, 2'b10);
    cyc("r27_ch0b",    1'b0, 2'b00, 2'b10);
    rep("r27_wait2", 4, 1'b0, 2'b00, 2'b10);
    cyc("r27_fall",    1'b0, 2'b00, 2'b00);
    rep("r27_low",  2, 1'b0, 2'b00, 2'b00);

    // reset mid-count discards progress; ch1 stays low throughout
    rep("r28_cnt", 5, 1'b0, 2'b01, 2'b00);
    chk("r28_cnt3", dut.g_ch[0].u_ch.cnt_q, 16'd3);
    #2;
    rst = 1'b1;
    #1;
    chk("r28_async_db",  {14'd0, btn_db}, 16'd0);
    chk("r28_async_cnt", dut.g_ch[0].u_ch.cnt_q, 16'd0);
    rep("r28_rst",  2, 1'b1, 2'b01, 2'b00);
    rep("r28_wait", 5, 1'b0, 2'b01, 2'b00);
    cyc("r28_rise",    1'b0, 2'b01, 2'b01);
    rep("r30_hold", 4, 1'b0, 2'b01, 2'b01);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
